scalar_writeback: RTL and testbench

SCALAR_WRITEBACK -- requirements
Module: scalar_writeback

---
 rtl/scalar_writeback.sv | 170 +++++++++++++++++
 tb/tb_scalar_writeback.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/scalar_writeback.sv
// Scalar writeback: one single-entry result buffer per functional unit (alu, ld, br),
// a round-robin arbiter picking one buffered result per cycle, and registered regfile-write/done outputs.
module swb_slot #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_wen,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              ready,
  output logic              slot_valid,
  output logic              slot_wen,
  output logic [REG_W-1:0]  slot_rd,
  output logic [DATA_W-1:0] slot_data
);
  // A granted entry frees its slot in the same cycle, so a back-to-back producer never stalls.
  assign ready = nRST & ~flush & (~slot_valid | grant);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      slot_valid <= 1'b0;
      slot_wen   <= 1'b0;
      slot_rd    <= '0;
      slot_data  <= '0;
    end else if (flush) begin
      slot_valid <= 1'b0;
    end else if (in_valid && ready) begin
      slot_valid <= 1'b1;
      slot_wen   <= in_wen;
      slot_rd    <= in_rd;
      slot_data  <= in_data;
    end else if (grant) begin
      slot_valid <= 1'b0;
    end
  end
endmodule

module scalar_writeback #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic              alu_wen,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_wen,
  input  logic [REG_W-1:0]  ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic              br_wen,
  input  logic [REG_W-1:0]  br_rd,
  input  logic [DATA_W-1:0] br_data,
  output logic              wb_rw_en,
  output logic [REG_W-1:0]  wb_rw,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_alu_done,
  output logic              wb_load_done,
  output logic              wb_branch_done
);
  localparam int NUM_SRC = 3;

  typedef struct packed {
    logic               rw_en;
    logic [REG_W-1:0]   rw;
    logic [DATA_W-1:0]  wdata;
    logic [NUM_SRC-1:0] done;
  } wb_t;

  logic [NUM_SRC-1:0]             src_valid, src_wen, src_ready;
  logic [NUM_SRC-1:0][REG_W-1:0]  src_rd;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]             buf_valid, buf_wen, grant;
  logic [NUM_SRC-1:0][REG_W-1:0]  buf_rd;
  logic [NUM_SRC-1:0][DATA_W-1:0] buf_data;

  assign src_valid = {br_valid, ld_valid, alu_valid};
  assign src_wen   = {br_wen, ld_wen, alu_wen};
  assign src_rd    = {br_rd, ld_rd, alu_rd};
  assign src_data  = {br_data, ld_data, alu_data};
  assign {br_ready, ld_ready, alu_ready} = src_ready;

  generate
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
      swb_slot #(.DATA_W(DATA_W), .REG_W(REG_W)) u_slot (
        .CLK        (CLK),
        .nRST       (nRST),
        .flush      (flush),
        .in_valid   (src_valid[k]),
        .in_wen     (src_wen[k]),
        .in_rd      (src_rd[k]),
        .in_data    (src_data[k]),
        .grant      (grant[k]),
        .ready      (src_ready[k]),
        .slot_valid (buf_valid[k]),
        .slot_wen   (buf_wen[k]),
        .slot_rd    (buf_rd[k]),
        .slot_data  (buf_data[k])
      );
    end
  endgenerate

  logic [1:0] rr_ptr, gnt_idx, idx;
  logic [2:0] sum;
  logic       gnt_any;

  // Search starts at rr_ptr and wraps; a flush cycle grants nothing.
  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    idx     = 2'd0;
    sum     = 3'd0;
    if (!flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        sum = {1'b0, rr_ptr} + 3'(i);
        idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        if (!gnt_any && buf_valid[idx]) begin
          gnt_any    = 1'b1;
          gnt_idx    = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  wb_t wb_d, wb_q;

  // x0 is never written, but its done pulse still fires.
  always_comb begin
    wb_d = '0;
    if (gnt_any) begin
      wb_d.done  = grant;
      wb_d.rw_en = buf_wen[gnt_idx] && (buf_rd[gnt_idx] != '0);
      if (wb_d.rw_en) begin
        wb_d.rw    = buf_rd[gnt_idx];
        wb_d.wdata = buf_data[gnt_idx];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr <= 2'd0;
      wb_q   <= '0;
    end else begin
      wb_q <= wb_d;
      if (flush)        rr_ptr <= 2'd0;
      else if (gnt_any) rr_ptr <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end
  end

  assign wb_rw_en       = wb_q.rw_en;
  assign wb_rw          = wb_q.rw;
  assign wb_wdata       = wb_q.wdata;
  assign wb_alu_done    = wb_q.done[0];
  assign wb_load_done   = wb_q.done[1];
  assign wb_branch_done = wb_q.done[2];
endmodule

// File: tb/tb_scalar_writeback.sv
// Directed bench for scalar_writeback: cycle-by-cycle vector table plus a mid-operation reset sequence.
module tb_scalar_writeback;
  logic        CLK = 1'b0;
  logic        nRST, flush;
  logic        alu_valid, alu_ready, alu_wen;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready, ld_wen;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        br_valid, br_ready, br_wen;
  logic [4:0]  br_rd;
  logic [31:0] br_data;
  logic        wb_rw_en;
  logic [4:0]  wb_rw;
  logic [31:0] wb_wdata;
  logic        wb_alu_done, wb_load_done, wb_branch_done;

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  scalar_writeback #(.DATA_W(32), .REG_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wen(alu_wen), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wen(ld_wen), .ld_rd(ld_rd), .ld_data(ld_data),
    .br_valid(br_valid), .br_ready(br_ready), .br_wen(br_wen), .br_rd(br_rd), .br_data(br_data),
    .wb_rw_en(wb_rw_en), .wb_rw(wb_rw), .wb_wdata(wb_wdata),
    .wb_alu_done(wb_alu_done), .wb_load_done(wb_load_done), .wb_branch_done(wb_branch_done)
  );

  // Index 0 = alu, 1 = ld, 2 = br; expectations describe the cycle in which the inputs are driven.
  typedef struct {
    logic [2:0]       v, wen;
    logic [2:0][4:0]  rd;
    logic [2:0][31:0] data;
    logic             fl;
    logic [2:0]       rdy;
    logic             en;
    logic [4:0]       rw;
    logic [31:0]      wd;
    logic [2:0]       done;
  } vec_t;

  function automatic vec_t ex(input logic [2:0] rdy, input logic en, input logic [4:0] rw,
                              input logic [31:0] wd, input logic [2:0] done, input logic fl = 1'b0);
    vec_t x;
    x.v = '0; x.wen = '0; x.rd = '0; x.data = '0;
    x.fl = fl; x.rdy = rdy; x.en = en; x.rw = rw; x.wd = wd; x.done = done;
    return x;
  endfunction

  function automatic vec_t src(input vec_t x, input int k, input logic wen,
                               input logic [4:0] rd, input logic [31:0] d);
    x.v[k] = 1'b1; x.wen[k] = wen; x.rd[k] = rd; x.data[k] = d;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] rdy, input logic en,
                            input logic [4:0] rw, input logic [31:0] wd, input logic [2:0] done);
    chk({tag, ".ready"}, {29'd0, br_ready, ld_ready, alu_ready}, {29'd0, rdy});
    chk({tag, ".rw_en"}, {31'd0, wb_rw_en}, {31'd0, en});
    chk({tag, ".rw"},    {27'd0, wb_rw}, {27'd0, rw});
    chk({tag, ".wdata"}, wb_wdata, wd);
    chk({tag, ".done"},  {29'd0, wb_branch_done, wb_load_done, wb_alu_done}, {29'd0, done});
  endtask

  task automatic drive(input vec_t x);
    flush = x.fl;
    {br_valid, ld_valid, alu_valid} = x.v;
    {br_wen, ld_wen, alu_wen}       = x.wen;
    alu_rd = x.rd[0]; ld_rd = x.rd[1]; br_rd = x.rd[2];
    alu_data = x.data[0]; ld_data = x.data[1]; br_data = x.data[2];
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = ex(3'b000, 1'b0, 5'd0, 32'd0, 3'b000);
    nRST = 1'b0;
    drive(idle);
    #2 check_outs("reset", 3'b000, 1'b0, 5'd0, 32'd0, 3'b000);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // All three at once from rr_ptr=0: alu, ld, br drain on consecutive cycles.
    tbl.push_back(src(src(src(ex(3'b111,0,0,0,3'b000),0,1,5'd1,32'h11),1,1,5'd2,32'h22),2,1,5'd3,32'h33));
    tbl.push_back(ex(3'b001,0,0,0,3'b000));
    tbl.push_back(ex(3'b011,1,5'd1,32'h11,3'b001));
    tbl.push_back(ex(3'b111,1,5'd2,32'h22,3'b010));
    tbl.push_back(ex(3'b111,1,5'd3,32'h33,3'b100));
    // Single ALU result: two-edge latency, one-cycle pulse.
    tbl.push_back(src(ex(3'b111,0,0,0,3'b000),0,1,5'd5,32'hDEADBEEF));
    tbl.push_back(ex(3'b111,0,0,0,3'b000));
    tbl.push_back(ex(3'b111,1,5'd5,32'hDEADBEEF,3'b001));
    // Load to x0: done fires, no write.
    tbl.push_back(src(ex(3'b111,0,0,0,3'b000),1,1,5'd0,32'h1234));
    tbl.push_back(ex(3'b111,0,0,0,3'b000));
    tbl.push_back(ex(3'b111,0,0,0,3'b010));
    // Back-to-back ALU results at full throughput.
    tbl.push_back(src(ex(3'b111,0,0,0,3'b000),0,1,5'd7,32'h100));
    tbl.push_back(src(ex(3'b111,0,0,0,3'b000),0,1,5'd8,32'h101));
    tbl.push_back(src(ex(3'b111,1,5'd7,32'h100,3'b001),0,1,5'd9,32'h102));
    tbl.push_back(src(ex(3'b111,1,5'd8,32'h101,3'b001),0,1,5'd10,32'h103));
    tbl.push_back(ex(3'b111,1,5'd9,32'h102,3'b001));
    tbl.push_back(ex(3'b111,1,5'd10,32'h103,3'b001));
    // Branch with wen=0.
    tbl.push_back(src(ex(3'b111,0,0,0,3'b000),2,0,5'd4,32'h55));
    tbl.push_back(ex(3'b111,0,0,0,3'b000));
    tbl.push_back(ex(3'b111,0,0,0,3'b100));
    tbl.push_back(ex(3'b111,0,0,0,3'b000));
    // Flush with ld/br pending and rr_ptr=1: nothing drains, rr_ptr returns to 0.
    tbl.push_back(src(ex(3'b111,0,0,0,3'b000),0,1,5'd12,32'hA0));
    tbl.push_back(src(src(ex(3'b111,0,0,0,3'b000),1,1,5'd13,32'hB0),2,1,5'd14,32'hC0));
    tbl.push_back(ex(3'b000,1,5'd12,32'hA0,3'b001,1'b1));
    for (int i = 0; i < 4; i++) tbl.push_back(ex(3'b111,0,0,0,3'b000));
    // alu and br together: alu must win first if rr_ptr is 0.
    tbl.push_back(src(src(ex(3'b111,0,0,0,3'b000),0,1,5'd15,32'hD0),2,1,5'd16,32'hE0));
    tbl.push_back(ex(3'b011,0,0,0,3'b000));
    tbl.push_back(ex(3'b111,1,5'd15,32'hD0,3'b001));
    tbl.push_back(ex(3'b111,1,5'd16,32'hE0,3'b100));
    tbl.push_back(ex(3'b111,0,0,0,3'b000));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      drive(tbl[i]);
      #1 check_outs($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].en, tbl[i].rw, tbl[i].wd, tbl[i].done);
    end

    // Reset while the br buffer is full and alu's writeback is on the outputs.
    @(negedge CLK);
    drive(src(src(idle,0,1,5'd17,32'hF0),2,1,5'd18,32'hBB));
    @(negedge CLK);
    drive(idle);
    @(negedge CLK);
    #1 check_outs("rst_pre", 3'b111, 1'b1, 5'd17, 32'hF0, 3'b001);
    #2 nRST = 1'b0;
    #1 check_outs("rst_async", 3'b000, 1'b0, 5'd0, 32'd0, 3'b000);
    @(negedge CLK);
    #1 check_outs("rst_hold", 3'b000, 1'b0, 5'd0, 32'd0, 3'b000);
    @(negedge CLK);
    nRST = 1'b1;
    #1 check_outs("rst_rel", 3'b111, 1'b0, 5'd0, 32'd0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1 check_outs($sformatf("rst_after%0d", i), 3'b111, 1'b0, 5'd0, 32'd0, 3'b000);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
